rx_fsm: RTL and testbench
=========================

// Module: rx_fsm
// PURPOSE
//  Receive half of the serial full-duplex module. On a start command from the top-level
//  controller, generates the serial clock sck_rx (clk/2) and shifts in 32 bits from data_rx, LSB first.
//  It then presents the word on receive_data and signals completion to the controlling FSM.
//  Remote transmitter updates data_rx on the rising edge of sck_rx; this block samples at the falling edge.
// PARAMETERS
//  none (word length fixed at 32 bits; half-period counter fixed at 6 bits)
// PORTS
//  clk           in   1   system clock; all state changes on posedge clk
//  rst           in   1   reset; asynchronous, active-high
//  state_in      in   2   command: 2'd1 = start receive, 2'd2 = abort, 2'd0/2'd3 = no-op
//  data_rx       in   1   serial data from remote transmitter
//  receive_data  out  32  last complete received word (registered, held until next LATCH)
//  sck_rx        out  1   serial clock to remote transmitter (registered)
//  latch_flag    out  1   high exactly one cycle when receive_data is updated
//  finish        out  1   level: last reception completed; cleared on next start/abort/reset
//  finish_fsm    out  1   one-cycle pulse to controlling FSM at end of reception
// BEHAVIOUR
//  - Internal regs: state[2:0], cnt[5:0] (half-period counter), shreg[31:0].
//  - States: IDLE=3'd0, START=3'd1, SHIFT=3'd2, LATCH=3'd3, DONE=3'd4; 5-7 illegal -> IDLE.
//  - Reset (async, rst=1): state=IDLE, cnt=0, shreg=0, receive_data=0, sck_rx=0, latch_flag=0,
//    finish=0, finish_fsm=0.
//  - IDLE: sck_rx=0. If state_in==1 -> START, clear cnt/shreg, clear finish. Other codes stay in IDLE.
//  - START: one cycle, sck_rx=0, -> SHIFT.
//  - SHIFT: every clk, sck_rx<=~sck_rx and cnt<=cnt+1.
//    When sck_rx==1 (falling edge being generated): shreg<={data_rx,shreg[31:1]}.
//    First edge in SHIFT is rising. 64 cycles = 32 sck_rx periods = 32 samples.
//    When cnt==63: cnt wraps to 0, sck_rx returns to 0, -> LATCH.
//  - LATCH: receive_data<=shreg (visible while latch_flag=1); latch_flag=1 this cycle only -> DONE.
//  - DONE: finish_fsm=1 this cycle only, finish<=1 (held), -> IDLE.
//  - Bit ordering: first bit received lands in receive_data[0], 32nd bit in receive_data[31].
//  - Timing: start sampled at edge N -> START. SHIFT occupies N+2..N+65. LATCH at N+66. DONE at N+67.
//  - state_in==1 while in START/SHIFT/LATCH/DONE: ignored (no restart).
//  - state_in==2 in START or SHIFT: abort -> IDLE next cycle, sck_rx=0, cnt=0.
//    receive_data unchanged; no latch_flag/finish_fsm; finish stays 0.
//  - Start at IDLE immediately after DONE is accepted: back-to-back words allowed. finish drops on start.
//  - Reset mid-operation: immediate return to all reset values, including receive_data=0.
//  - latch_flag and finish_fsm never both high in the same cycle.
// TESTING
//  - Reset: rst=1 for 2 clk -> all outputs 0, state=IDLE. sck_rx stays 0 with state_in=0 for 10 clk.
//  - Single word: state_in=1 for 2 clk then 0. Bench drives 0x56D01953 LSB first on posedge sck_rx.
//    -> exactly 32 sck_rx rising edges; latch_flag 1 cycle; receive_data=0x56D01953; then finish_fsm 1 cycle, finish=1.
//  - Patterns: 0xFFFFFFFF, 0x00000001, 0x80000000 -> received exactly (checks LSB-first ordering).
//  - Abort: start, then state_in=2 after 10 clk -> IDLE, sck_rx=0, no latch_flag.
//    receive_data keeps previous word.
//  - Reset mid-SHIFT (after 20 clk): rst pulse -> outputs cleared immediately. Subsequent start receives a full word correctly.
//  - Back-to-back: start again in the cycle after DONE with 0xA5A5A5A5 -> second word latched.
//    finish low during the second word.

Source files
------------

// File: rtl/rx_fsm.sv
// Receive half of the serial full-duplex link: generates sck_rx at clk/2, shifts in a
// 32-bit word LSB first on the falling sck_rx edges, then latches it and reports completion.
module rx_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state_in,
    input  logic        data_rx,
    output logic [31:0] receive_data,
    output logic        sck_rx,
    output logic        latch_flag,
    output logic        finish,
    output logic        finish_fsm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_ABORT = 2'd2;
    localparam logic [5:0] CNT_LAST  = 6'd63;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_shreg;

    logic w_start;
    logic w_abort;

    assign w_start = (state_in == CMD_START);
    assign w_abort = (state_in == CMD_ABORT);

    // NOTE: every state register is updated with <= so all branches see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            receive_data <= '0;
            sck_rx       <= 1'b0;
            latch_flag   <= 1'b0;
            finish       <= 1'b0;
            finish_fsm   <= 1'b0;
        end else begin
            // Pulse outputs default low; only LATCH/DONE raise them, for one cycle each.
            latch_flag <= 1'b0;
            finish_fsm <= 1'b0;

            case (r_state)
                IDLE: begin
                    sck_rx <= 1'b0;
                    if (w_start) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                        finish  <= 1'b0;
                    end
                end

                START: begin
                    sck_rx <= 1'b0;
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        sck_rx  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        sck_rx <= ~sck_rx;
                        r_cnt  <= r_cnt + 6'd1;
                        // sck_rx high now means this edge drives it low: sample here.
                        if (sck_rx) begin
                            r_shreg <= {data_rx, r_shreg[31:1]};
                        end
                        if (r_cnt == CNT_LAST) begin
                            sck_rx  <= 1'b0;
                            r_state <= LATCH;
                        end
                    end
                end

                LATCH: begin
                    receive_data <= r_shreg;
                    latch_flag   <= 1'b1;
                    r_state      <= DONE;
                end

                DONE: begin
                    finish_fsm <= 1'b1;
                    finish     <= 1'b1;
                    r_state    <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    sck_rx  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fsm.sv
// Self-checking bench for rx_fsm: acts as the remote transmitter and compares each received
// word and its handshake timing against what it sent.
module tb_rx_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state_in;
    logic        data_rx;
    logic [31:0] receive_data;
    logic        sck_rx;
    logic        latch_flag;
    logic        finish;
    logic        finish_fsm;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_word;

    always #5 clk = ~clk;

    rx_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .state_in     (state_in),
        .data_rx      (data_rx),
        .receive_data (receive_data),
        .sck_rx       (sck_rx),
        .latch_flag   (latch_flag),
        .finish       (finish),
        .finish_fsm   (finish_fsm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start a reception (state_in=1 held for 'hold' edges) and play the transmitter.
    // Called right after a negedge; returns on the negedge after the DONE edge.
    task automatic run_word(input logic [31:0] w, input int hold);
        int          lat_k   = -1;
        int          ffsm_k  = -1;
        int          lat_n   = 0;
        int          ffsm_n  = 0;
        int          rises   = 0;
        int          both    = 0;
        int          fin_bad = 0;
        logic [31:0] lat_val = '0;
        logic        prev_sck;
        prev_sck = sck_rx;
        state_in = 2'd1;
        for (int k = 0; k <= 67; k++) begin
            @(negedge clk);
            if (k + 1 >= hold) state_in = 2'd0;
            if (sck_rx && !prev_sck) begin
                if (rises < 32) data_rx = w[rises];
                rises++;
            end else if (!sck_rx && prev_sck) begin
                data_rx = 1'($urandom_range(0, 1));
            end
            prev_sck = sck_rx;
            if (latch_flag) begin
                lat_n++;
                if (lat_k < 0) begin
                    lat_k   = k;
                    lat_val = receive_data;
                end
            end
            if (finish_fsm) begin
                ffsm_n++;
                if (ffsm_k < 0) ffsm_k = k;
            end
            if (latch_flag && finish_fsm) both++;
            if (k < 67 && finish) fin_bad++;
        end
        check("sck_rises",    rises,   32);
        check("latch_cycle",  lat_k,   66);
        check("latch_count",  lat_n,   1);
        check("word",         lat_val, w);
        check("ffsm_cycle",   ffsm_k,  67);
        check("ffsm_count",   ffsm_n,  1);
        check("pulse_overlap", both,   0);
        check("finish_low",   fin_bad, 0);
        check("finish_high",  finish,  1);
        check("word_held",    receive_data, w);
        check("sck_idle",     sck_rx,  0);
        last_word = w;
    endtask

    // Start, then abort on the edge 'at' cycles after the start edge.
    task automatic run_abort(input int at);
        int sck_hi = 0;
        int lat_n  = 0;
        int ffsm_n = 0;
        int fin_n  = 0;
        state_in = 2'd1;
        @(negedge clk);
        state_in = 2'd0;
        repeat (at - 1) @(negedge clk);
        state_in = 2'd2;
        @(negedge clk);
        state_in = 2'd0;
        check("abort_sck", sck_rx, 0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sck_rx) sck_hi++;
            if (latch_flag) lat_n++;
            if (finish_fsm) ffsm_n++;
            if (finish) fin_n++;
        end
        check("abort_sck_quiet", sck_hi, 0);
        check("abort_no_latch",  lat_n,  0);
        check("abort_no_ffsm",   ffsm_n, 0);
        check("abort_finish",    fin_n,  0);
        check("abort_keep_word", receive_data, last_word);
    endtask

    initial begin
        int sck_hi;
        int pulses;
        rst       = 1'b1;
        state_in  = 2'd0;
        data_rx   = 1'b0;
        last_word = '0;

        // Reset and quiet idle, including the no-op command 3.
        repeat (2) @(negedge clk);
        check("rst_data",   receive_data, 0);
        check("rst_sck",    sck_rx,       0);
        check("rst_latch",  latch_flag,   0);
        check("rst_finish", finish,       0);
        check("rst_ffsm",   finish_fsm,   0);
        rst    = 1'b0;
        sck_hi = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            state_in = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            @(negedge clk);
            if (sck_rx) sck_hi++;
            if (latch_flag || finish_fsm || finish) pulses++;
        end
        state_in = 2'd0;
        check("idle_sck",    sck_hi, 0);
        check("idle_pulses", pulses, 0);

        // Directed words.
        run_word(32'h56D01953, 2);
        run_word(32'hFFFFFFFF, 2);
        run_word(32'h00000001, 2);
        run_word(32'h80000000, 2);

        // Abort mid-shift keeps the previous word.
        repeat (3) @(negedge clk);
        run_abort(10);

        // Asynchronous reset in the middle of a shift.
        state_in = 2'd1;
        @(negedge clk);
        state_in = 2'd0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", receive_data, 0);
        check("mid_rst_sck",  sck_rx,       0);
        check("mid_rst_flags", {29'd0, latch_flag, finish, finish_fsm}, 0);
        @(negedge clk);
        rst       = 1'b0;
        last_word = '0;
        @(negedge clk);
        run_word($urandom, 2);

        // Back-to-back: second start on the first edge after DONE.
        run_word($urandom, 2);
        run_word(32'hA5A5A5A5, 2);

        // Randomised mix of words, long start holds, gaps and aborts.
        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) run_abort($urandom_range(1, 65));
            else run_word($urandom, $urandom_range(1, 60));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
